pipe_sel_mux: RTL

//  Parametrised N-way, W-bit selector with a registered valid/ready output stage.

---
 rtl/pipe_sel_mux_pkg.sv | 11 +
 rtl/pipe_sel_mux_mux_nxw.sv | 22 ++
 rtl/pipe_sel_mux.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pipe_sel_mux_pkg.sv
// Shared types for the pipelined N:1 select stage.
package pipe_sel_mux_pkg;

    // Occupancy of the output stage: main register, then main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } st_e;

endpackage

// File: rtl/pipe_sel_mux_mux_nxw.sv
// Combinational N-way, W-bit selector with out-of-range select flag.
module mux_nxw #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] a,
    input  logic [SEL_W-1:0]        s,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    // Unmatched select values fall through to zero data.
    always_comb begin
        data = '0;
        err  = (int'(s) >= NUM_IN);
        for (int k = 0; k < NUM_IN; k++) begin
            if (s == SEL_W'(k)) data = a[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/pipe_sel_mux.sv
// N-way selector feeding a registered valid/ready output stage, optional skid.
module pipe_sel_mux
    import pipe_sel_mux_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4,
    parameter bit SKID   = 1'b1,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    CLK,
    input  logic                    CLRN,
    input  logic [NUM_IN*WIDTH-1:0] A,
    input  logic [SEL_W-1:0]        S,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        Y,
    output logic [SEL_W-1:0]        y_sel,
    output logic                    y_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int EW = WIDTH + SEL_W + 1;

    logic [WIDTH-1:0] m_data;
    logic             m_err;
    logic [EW-1:0]    in_ent;
    logic [EW-1:0]    main_d;
    logic             load_main;
    logic             pop;

    mux_nxw #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_mux (
        .a    (A),
        .s    (S),
        .data (m_data),
        .err  (m_err)
    );

    assign in_ent = {m_data, S, m_err};
    assign pop    = out_valid & out_ready;

    generate
        if (SKID) begin : g_skid
            st_e           st, st_nx;
            logic          acc;
            logic          load_skid;
            logic          from_skid;
            logic [EW-1:0] skid_q;

            // in_ready decodes registered state only, so out_ready never reaches it.
            assign in_ready  = (st != ST_TWO);
            assign out_valid = (st != ST_EMPTY);
            assign acc       = in_valid & in_ready;
            assign main_d    = from_skid ? skid_q : in_ent;

            always_comb begin
                st_nx     = st;
                load_main = 1'b0;
                load_skid = 1'b0;
                from_skid = 1'b0;
                if (flush) begin
                    st_nx = ST_EMPTY;
                end else begin
                    case (st)
                        ST_EMPTY: if (acc) begin
                            st_nx     = ST_ONE;
                            load_main = 1'b1;
                        end
                        ST_ONE: begin
                            if (acc && !pop) begin
                                st_nx     = ST_TWO;
                                load_skid = 1'b1;
                            end else if (!acc && pop) begin
                                st_nx = ST_EMPTY;
                            end else if (acc) begin
                                load_main = 1'b1;
                            end
                        end
                        ST_TWO: if (pop) begin
                            st_nx     = ST_ONE;
                            load_main = 1'b1;
                            from_skid = 1'b1;
                        end
                        default: st_nx = ST_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge CLK or negedge CLRN) begin
                if (!CLRN) st <= ST_EMPTY;
                else       st <= st_nx;
            end

            always_ff @(posedge CLK or negedge CLRN) begin
                if (!CLRN)          skid_q <= '0;
                else if (load_skid) skid_q <= in_ent;
            end
        end else begin : g_noskid
            logic vld_q;
            logic acc;

            assign in_ready  = ~vld_q | out_ready;
            assign out_valid = vld_q;
            assign acc       = in_valid & in_ready;
            assign load_main = acc & ~flush;
            assign main_d    = in_ent;

            always_ff @(posedge CLK or negedge CLRN) begin
                if (!CLRN)      vld_q <= 1'b0;
                else if (flush) vld_q <= 1'b0;
                else if (acc)   vld_q <= 1'b1;
                else if (pop)   vld_q <= 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN)          {Y, y_sel, y_err} <= '0;
        else if (load_main) {Y, y_sel, y_err} <= main_d;
    end

endmodule
